nibble_seq_adder: RTL and testbench

NIBBLE_SEQ_ADDER -- requirements
Module: nibble_seq_adder

---
 rtl/nibble_seq_adder.sv | 119 +++++++++++
 tb/tb_nibble_seq_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_seq_adder.sv
// Sequential W-bit adder/subtractor that reuses one external 4-bit adder slice,
// processing one nibble per clock from least to most significant.
module nibble_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   result;
    logic [IW+1:0]  bit_base;
    logic           accept;

    // Lowest bit position of the nibble currently being processed.
    assign bit_base = {idx, 2'b00};
    assign accept   = in_valid && (state == IDLE);

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk the nibbles in RUN, wait for hand-off in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)         state_next = RUN;
            RUN:  if (idx == LAST)      state_next = DONE;
            DONE: if (out_ready)        state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then fold one slice result per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
        end else if (accept) begin
            idx   <= '0;
            carry <= in_sub ? 1'b1 : in_cin;
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
        end else if (state == RUN) begin
            result[bit_base +: 4] <= add_s;
            carry                 <= add_cout;
            if (idx != LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Outputs decoded from state; everything is forced low while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        out_ovf   = 1'b0;
        case (state)
            IDLE: in_ready = rst_n;
            RUN: begin
                add_a   = a_reg[bit_base +: 4];
                add_b   = b_reg[bit_base +: 4];
                add_cin = carry;
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = result;
                out_cout  = carry;
                out_ovf   = (a_reg[W-1] == b_reg[W-1]) && (result[W-1] != a_reg[W-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Directed and randomized checks for nibble_seq_adder with a behavioral 4-bit slice.
module tb_nibble_seq_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int vectors = 0;
    int miscompares = 0;

    int         lat;
    logic [3:0] cin_seq;
    logic [3:0] b_nib0;
    logic [W-1:0] held_sum;

    nibble_seq_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    // External 4-bit adder slice
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Accepts one request, scrambles operands during RUN, records slice traffic and latency.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        int wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(posedge clk); #1; wait_cnt++;
        end
        checkOutput("ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; cin_seq = 4'h0; b_nib0 = 4'h0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) cin_seq[lat] = add_cin;
            if (lat == 0) b_nib0 = add_b;
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handOff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] eb;
        logic [W:0]   full;
        logic         ovf;
        eb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == eb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {in_ready, out_valid, out_cout, out_ovf, add_cin, add_a, add_b}, 32'd0);
        checkOutput("reset_sum", out_sum, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", {31'b0, in_ready}, 32'd1);

        // 0xFFFF + 0x0001: full carry ripple
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("ffff_latency", lat, 32'd4);
        checkOutput("ffff_result", {out_cout, out_ovf, out_sum}, {2'b10, 16'h0000});
        handOff();

        // 0x7FFF + 0x0001: signed overflow
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("7fff_result", {out_cout, out_ovf, out_sum}, {2'b01, 16'h8000});
        checkOutput("7fff_cin_seq", cin_seq, 4'b1110);
        handOff();

        // 0x0005 - 0x0007: borrow
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
        checkOutput("sub_result", {out_cout, out_ovf, out_sum}, {2'b00, 16'hFFFE});
        checkOutput("sub_b_nib0", b_nib0, 4'h8);
        handOff();

        // Consumer stalls 3 cycles in DONE while in_valid is asserted
        applyStimulus(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        checkOutput("stall_result", {out_cout, out_ovf, out_sum}, {2'b00, 16'h1001});
        held_sum = out_sum;
        in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_hold", {in_ready, out_valid, out_cout, out_ovf, out_sum}, {4'b0100, 16'h1001});
        end
        in_valid = 1'b0;
        handOff();
        checkOutput("after_handoff", {in_ready, out_valid}, 2'b10);

        // Reset in the middle of RUN
        in_a = 16'h4321; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ctrl", {in_ready, out_valid, out_cout, out_ovf, add_cin, add_a, add_b}, 32'd0);
        checkOutput("abort_sum", out_sum, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            checkOutput("abort_no_valid", seen, 32'd0);
        end
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        checkOutput("post_abort_result", {out_cout, out_ovf, out_sum}, {2'b00, 16'h2345});
        handOff();

        // Back-to-back random traffic with in_valid and out_ready held high
        begin
            logic [W+1:0] expq[$];
            logic [W+1:0] exp_v;
            int accepted = 0;
            int got = 0;
            int gap = 0;
            int cyc = 0;
            bit took;
            out_ready = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
            in_valid = 1'b1;
            while (got < 1000 && cyc < 20000) begin
                took = 1'b0;
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        checkOutput("rand_spurious_valid", {31'b0, out_valid}, 32'd0);
                    end else begin
                        exp_v = expq.pop_front();
                        checkOutput("rand_result", {out_cout, out_ovf, out_sum}, exp_v);
                        got++;
                    end
                end
                if (in_ready && in_valid) begin
                    if (accepted > 0) checkOutput("rand_busy_gap", gap, N + 1);
                    expq.push_back(model(in_a, in_b, in_cin, in_sub));
                    accepted++;
                    gap = 0;
                    took = 1'b1;
                end else if (!in_ready) begin
                    gap++;
                end
                @(posedge clk); #1;
                cyc++;
                if (took) begin
                    in_a = W'($urandom); in_b = W'($urandom);
                    in_cin = 1'($urandom); in_sub = 1'($urandom);
                    if (accepted >= 1000) in_valid = 1'b0;
                end
            end
            checkOutput("rand_count", got, 32'd1000);
            out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
